// File: rtl/leiwand_rv32_mem_loader_pkg.sv
// Shared types and constants for the boot-time memory loader.
// Bus widths mirror the core's leiwand_rv32_constants values.
package leiwand_rv32_mem_loader_pkg;
  localparam int RV_XLEN    = 32;
  localparam int BE_W       = RV_XLEN / 8;
  localparam int LANE_W     = $clog2(BE_W);
  localparam int HDR_BYTES  = 4;
  localparam int HDR_CNT_W  = $clog2(HDR_BYTES);

  typedef enum logic [2:0] {
    S_ADDR,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [RV_XLEN-1:0] addr;
    logic [RV_XLEN-1:0] data;
    logic [BE_W-1:0]    wen;
  } mem_req_t;
endpackage

// File: rtl/leiwand_rv32_loader_packer.sv
// Byte-to-word packer: steers each payload byte into its lane and accumulates
// data/enables until the word is full or the stream ends.
module leiwand_rv32_loader_packer
  import leiwand_rv32_mem_loader_pkg::*;
(
  input  logic                  gclk,
  input  logic                  grst_n,
  input  logic                  take,
  input  logic [LANE_W-1:0]     lane,
  input  logic [7:0]            din,
  input  logic                  rem_one,
  output logic [BE_W-1:0][7:0]  data,
  output logic [BE_W-1:0]       wen,
  output logic                  flush
);
  logic full;
  logic last;

  assign full  = (lane == LANE_W'(BE_W - 1));
  assign last  = rem_one;
  assign flush = take & (full | last);

  // data/wen include the byte being taken this cycle so the top can latch
  // the complete word on the same edge that accepts its final byte.
  for (genvar g = 0; g < BE_W; g++) begin : g_lane
    logic       hit;
    logic [7:0] acc_b;
    logic       acc_w;

    assign hit     = take && (lane == LANE_W'(g));
    assign data[g] = hit ? din : acc_b;
    assign wen[g]  = hit | acc_w;

    always_ff @(posedge gclk) begin
      if (!grst_n) begin
        acc_b <= '0;
        acc_w <= 1'b0;
      end else if (flush) begin
        acc_b <= '0;
        acc_w <= 1'b0;
      end else if (hit) begin
        acc_b <= din;
        acc_w <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/leiwand_rv32_mem_loader.sv
// Boot loader initiator: parses {addr, len, payload} byte frames, writes the
// payload to RAM as 32-bit words and holds the core in reset until done.
module leiwand_rv32_mem_loader
  import leiwand_rv32_mem_loader_pkg::*;
#(
  parameter int XLEN = RV_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_byte_valid,
  input  logic [7:0]      i_byte,
  output logic            o_byte_ready,
  output logic            o_mem_valid,
  input  logic            i_mem_ready,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_data,
  output logic [3:0]      o_mem_wen,
  output logic            o_cpu_rst,
  output logic            o_busy,
  output logic            o_done,
  output logic [31:0]     o_checksum
);
  state_e                 state;
  state_e                 state_nxt;
  logic [HDR_CNT_W-1:0]   hdr_cnt;
  logic [31:0]            hdr_sh;
  logic [31:0]            hdr_word;
  logic                   hdr_last;
  logic [XLEN-1:0]        ptr;
  logic [31:0]            rem;
  mem_req_t               req_q;
  logic                   fire;
  logic                   hdr_fire;
  logic                   data_fire;
  logic                   wr_done;
  logic [BE_W-1:0][7:0]   pk_data;
  logic [BE_W-1:0]        pk_wen;
  logic                   pk_flush;

  assign fire      = i_byte_valid & o_byte_ready;
  assign hdr_fire  = fire && (state == S_ADDR || state == S_LEN);
  assign data_fire = fire && (state == S_DATA);
  assign wr_done   = (state == S_WRITE) && o_mem_valid && i_mem_ready;
  assign hdr_last  = (hdr_cnt == HDR_CNT_W'(HDR_BYTES - 1));
  // Little-endian header: bytes shift in from the top, first byte ends in [7:0].
  assign hdr_word  = {i_byte, hdr_sh[31:8]};

  leiwand_rv32_loader_packer u_packer (
    .gclk    (i_clk),
    .grst_n  (i_rst),
    .take    (data_fire),
    .lane    (ptr[LANE_W-1:0]),
    .din     (i_byte),
    .rem_one (rem == 32'd1),
    .data    (pk_data),
    .wen     (pk_wen),
    .flush   (pk_flush)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= S_ADDR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ADDR:  if (hdr_fire && hdr_last) state_nxt = S_LEN;
      S_LEN:   if (hdr_fire && hdr_last) state_nxt = (hdr_word == 32'd0) ? S_DONE : S_DATA;
      S_DATA:  if (pk_flush) state_nxt = S_WRITE;
      S_WRITE: if (wr_done) state_nxt = (rem == 32'd0) ? S_DONE : S_DATA;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_ADDR;
    endcase
  end

  always_comb begin
    o_byte_ready = (state == S_ADDR) || (state == S_LEN) || (state == S_DATA);
  end

  assign o_mem_addr = req_q.addr;
  assign o_mem_data = req_q.data;
  assign o_mem_wen  = req_q.wen;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      hdr_cnt     <= '0;
      hdr_sh      <= '0;
      ptr         <= '0;
      rem         <= '0;
      req_q       <= '0;
      o_mem_valid <= 1'b0;
      o_checksum  <= '0;
      o_cpu_rst   <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      if (hdr_fire) begin
        hdr_cnt <= hdr_cnt + 1'b1;
        hdr_sh  <= hdr_word;
        if (hdr_last && state == S_ADDR) ptr <= hdr_word;
        if (hdr_last && state == S_LEN)  rem <= hdr_word;
      end
      if (data_fire) begin
        ptr        <= ptr + 1'b1;
        rem        <= rem - 1'b1;
        o_checksum <= o_checksum + {24'd0, i_byte};
        if (pk_flush) begin
          req_q.addr  <= {ptr[XLEN-1:LANE_W], {LANE_W{1'b0}}};
          req_q.data  <= pk_data;
          req_q.wen   <= pk_wen;
          o_mem_valid <= 1'b1;
        end
      end
      if (wr_done) o_mem_valid <= 1'b0;
      // Status flags are registered from the next state so they line up with it.
      o_busy    <= (state_nxt == S_LEN) || (state_nxt == S_DATA) || (state_nxt == S_WRITE) ||
                   ((state_nxt == S_ADDR) && (hdr_cnt != '0 || hdr_fire));
      o_done    <= (state_nxt == S_DONE);
      o_cpu_rst <= (state_nxt != S_DONE);
    end
  end
endmodule
